// File: rtl/bcd_display_pkg.sv
// Shared definitions for the BCD 7-segment display driver.
//   state_t      : conversion FSM states
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : only segment g lit, used to flag overflow
//   seg_decode() : 0-9 nibble to active-low {g,f,e,d,c,b,a}; anything else blanks
//   pow10()      : elaboration-time power of ten for the overflow threshold
package bcd_display_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3_stage.sv
// Conditional add-3 correction applied to every BCD nibble before the
// double-dabble shift: any nibble >= 5 gets +3 so the following left shift
// carries correctly into the next decimal digit.
//   bcd : working BCD vector, DIGITS nibbles, nibble 0 least significant
//   adj : corrected vector, same layout
module bcd_add3_stage #(
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] bcd,
    output logic [4*DIGITS-1:0] adj
);

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        assign adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? (bcd[4*k +: 4] + 4'd3)
                                                       : bcd[4*k +: 4];
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Binary to multi-digit active-low 7-segment driver.
// A sequential double-dabble engine converts one input bit per clock; the
// display register only updates when a conversion finishes, so the digits
// never show intermediate values.
//   clk, rst  : clock, synchronous active-high reset
//   bin_i     : unsigned value, captured when load is accepted (busy=0)
//   load      : start a conversion; ignored while busy
//   blank_en  : blank leading zeros (digit 0 always shown), combinational
//   busy      : conversion in progress
//   done      : one-cycle pulse when the display register updates
//   overflow  : last accepted value did not fit in DIGITS decimal digits
//   seg       : digit k at seg[7k+6:7k], {g,f,e,d,c,b,a}, active-low
module bcd_display_driver
    import bcd_display_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_i,
    input  logic                  load,
    input  logic                  blank_en,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CMP_W = WIDTH + 4;

    // When 10^DIGITS does not fit in CMP_W bits no input can overflow, so the
    // threshold saturates to all-ones, which a zero-extended input never reaches.
    localparam logic [63:0]      POW10  = pow10(DIGITS);
    localparam logic [CMP_W-1:0] THRESH = (POW10 >= (64'd1 << CMP_W)) ? {CMP_W{1'b1}}
                                                                      : POW10[CMP_W-1:0];

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              last;
    logic [WIDTH-1:0]  sh;
    logic [BCD_W-1:0]  work;
    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  shifted;
    logic [BCD_W-1:0]  bcd_q;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_lat;

    bcd_add3_stage #(
        .DIGITS (DIGITS)
    ) u_add3 (
        .bcd (work),
        .adj (adj)
    );

    // Top corrected bit falls off; the overflow flag already covers that case.
    assign shifted = {adj[BCD_W-2:0], sh[WIDTH-1]};
    assign busy    = (state == SHIFT);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            work     <= '0;
            cnt      <= '0;
            ovf_lat  <= 1'b0;
            bcd_q    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= last;
            if (accept) begin
                sh      <= bin_i;
                work    <= '0;
                cnt     <= CNT_W'(WIDTH - 1);
                ovf_lat <= ({4'b0000, bin_i} >= THRESH);
            end else if (state == SHIFT) begin
                work <= shifted;
                sh   <= sh << 1;
                cnt  <= cnt - CNT_W'(1);
                if (last) begin
                    bcd_q    <= shifted;
                    overflow <= ovf_lat;
                end
            end
        end
    end

    // Scan from the most significant digit down; `lead` stays set while every
    // digit seen so far is zero, which is exactly the leading-zero condition.
    always_comb begin
        logic       lead;
        logic [3:0] nib;
        seg  = '0;
        lead = 1'b1;
        nib  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib  = bcd_q[4*k +: 4];
            lead = lead && (nib == 4'd0);
            if (overflow) begin
                seg[7*k +: 7] = SEG_DASH;
            end else if (blank_en && lead && (k != 0)) begin
                seg[7*k +: 7] = SEG_BLANK;
            end else begin
                seg[7*k +: 7] = seg_decode(nib);
            end
        end
    end

endmodule
